lsu_sram_bridge: RTL

Load/store unit for the multi-cycle LoongArch core. Sits between the core's EXE state and the data SRAM, replacing direct `data_sram_we/addr/wdata` drive with an SRAM-like request/response handshake. It accepts one memory operation at a time, generates byte strobes and replicated write data, waits for the memory response, then aligns and extends load data. The result is handed to WB through a valid/ready handshake.

---
 rtl/lsu_pkg.sv | 46 ++++
 rtl/lsu_load_align.sv | 24 ++
 rtl/lsu_sram_bridge.sv | 115 +++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared LSU definitions: op-field layout, FSM state codes, ALE exception code
// and the store strobe/replication and misalignment helpers.
package lsu_pkg;

  // in_op = {store, unsigned, size[1:0]}
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam int OP_STORE    = 3;
  localparam int OP_UNSIGNED = 2;

  typedef logic [1:0] lsu_state_t;
  localparam lsu_state_t ST_IDLE = 2'd0;
  localparam lsu_state_t ST_REQ  = 2'd1;
  localparam lsu_state_t ST_WAIT = 2'd2;
  localparam lsu_state_t ST_RESP = 2'd3;

  localparam logic [5:0] ECODE_ALE = 6'h09;

  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      default: return |off;
    endcase
  endfunction

  // Half strobes shift by the raw offset so an unchecked half at offset 3 truncates to 4'b1000.
  function automatic logic [3:0] lsu_wstrb(input logic [3:0] op, input logic [1:0] off);
    if (!op[OP_STORE]) return 4'b0000;
    case (op[1:0])
      SZ_B:    return 4'b0001 << off;
      SZ_H:    return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lsu_wdata(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_B:    return {4{wdata[7:0]}};
      SZ_H:    return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load aligner: shifts read data down by the byte offset, then
// truncates to the access size and sign- or zero-extends to 32 bits.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (size)
      SZ_B:    result = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
      SZ_H:    result = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_sram_bridge.sv
// LSU to data-SRAM bridge, one op at a time: req T+1, result >= T+3 (ALE: T+1); in_ready low until WB handshake.
// Misalignment check (out_ale/out_badv) only when LSU_ALIGN_CHECK_EN is defined.
module lsu_sram_bridge
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_wdata,
  input  logic [4:0]        in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_rdata,
  output logic [4:0]        out_dest,
  output logic              out_we,
  output logic              out_ale,
  output logic [ADDR_W-1:0] out_badv,
  output logic              data_sram_req,
  output logic              data_sram_wr,
  output logic [1:0]        data_sram_size,
  output logic [3:0]        data_sram_wstrb,
  output logic [ADDR_W-1:0] data_sram_addr,
  output logic [31:0]       data_sram_wdata,
  input  logic              data_sram_addr_ok,
  input  logic              data_sram_data_ok,
  input  logic [31:0]       data_sram_rdata
);

  lsu_state_t        state;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic [4:0]        dest_q;
  logic [31:0]       result_q;
  logic              ale_q;
  logic              misal;
  logic [31:0]       align_res;

`ifdef LSU_ALIGN_CHECK_EN
  assign misal = lsu_misaligned(in_op[1:0], in_addr[1:0]);
`else
  assign misal = 1'b0;
`endif

  lsu_load_align u_align (
    .rdata       (data_sram_rdata),
    .offset      (addr_q[1:0]),
    .size        (op_q[1:0]),
    .is_unsigned (op_q[OP_UNSIGNED]),
    .result      (align_res)
  );

  // Strobes and replicated data are computed at accept so the SRAM side sees only flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      op_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      dest_q   <= '0;
      result_q <= '0;
      ale_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_q     <= in_op;
            addr_q   <= in_addr;
            wdata_q  <= lsu_wdata(in_op[1:0], in_wdata);
            wstrb_q  <= lsu_wstrb(in_op, in_addr[1:0]);
            dest_q   <= in_dest;
            result_q <= '0;
            ale_q    <= misal;
            state    <= misal ? ST_RESP : ST_REQ;
          end
        end
        ST_REQ: begin
          if (data_sram_addr_ok) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (data_sram_data_ok) begin
            result_q <= op_q[OP_STORE] ? 32'h0 : align_res;
            state    <= ST_RESP;
          end
        end
        default: begin
          if (out_ready) state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready        = (state == ST_IDLE);
  assign data_sram_req   = (state == ST_REQ);
  assign data_sram_wr    = op_q[OP_STORE];
  assign data_sram_size  = op_q[1:0];
  assign data_sram_wstrb = wstrb_q;
  assign data_sram_addr  = addr_q;
  assign data_sram_wdata = wdata_q;

  assign out_valid = (state == ST_RESP);
  assign out_rdata = result_q;
  assign out_dest  = dest_q;
  assign out_we    = out_valid & ~op_q[OP_STORE] & ~ale_q;
  assign out_ale   = out_valid & ale_q;
  assign out_badv  = out_ale ? addr_q : '0;

endmodule
